mdu_pipelined: RTL and testbench

Parametrised multiply/divide unit for the RV M extension. It is the next generation of the core's single-radix MDU and sits beside the ALU in the execute stage.
- Operands and operation are latched at request acceptance.
- Multiplier has configurable pipeline depth; divider retires a configurable number of quotient bits per cycle.
- Adds req_ready back-pressure, back-to-back issue and a kill (flush) input for pipeline flushes and traps.

---
 rtl/mdu_pipelined.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_mdu_pipelined.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_pipelined.sv
// Pipelined RV M-extension multiply/divide unit with handshake, back-to-back issue and kill.
// Optional macro MDU_DIV_EARLY_OUT_EN: finish a divide in one cycle when |dividend| < |divisor|.

package mdu_pkg;
   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_AND    = 5'd2,
      ALU_OR     = 5'd3,
      ALU_XOR    = 5'd4,
      ALU_SLL    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_SLT    = 5'd8,
      ALU_SLTU   = 5'd9,
      ALU_LUI    = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_control_t;
endpackage

module mdu_pipelined
   import mdu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_BITS   = 1,
   parameter int MUL_STAGES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   src1,
   input  logic [XLEN-1:0]   src2,
   input  alu_control_t      mdu_control,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              kill,
   output logic              res_valid,
   input  logic              res_ack,
   output logic [XLEN-1:0]   mdu_result
);

   localparam int N_ITER = XLEN / DIV_BITS;
   localparam int CNT_W  = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(N_ITER - 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 0) ? (MUL_STAGES - 1) : 0);
   localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
      return ~v + XLEN'(1'b1);
   endfunction

   function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic sgn);
      return (sgn && v[XLEN-1]) ? negate(v) : v;
   endfunction

   state_t             state_r, state_n;
   logic [CNT_W-1:0]   cnt_r;
   logic               res_valid_r, valid_n;
   logic [XLEN-1:0]    mdu_result_r, result_n;

   logic [XLEN-1:0]    src1_r, src2_r;
   logic               a_signed_r, b_signed_r, mul_hi_r, rem_sel_r;
   logic               dz_r, ovf_r, q_neg_r, r_neg_r;
   logic [XLEN-1:0]    quo_r, rem_r, dvs_r;

   logic               is_mul_s, is_div_s, a_signed_s, b_signed_s, mul_hi_s;
   logic               div_signed_s, rem_sel_s;
   logic               req_ready_s, accept_s;
   state_t             target_s;

   logic [XLEN-1:0]    step_quo_s, step_rem_s;
   logic [XLEN:0]      trial_s;
   logic               early_s, div_fast_s;
   logic [XLEN-1:0]    div_res_s, mul_res_s;
   logic               load_div_s, load_mul_s;

   logic [2*XLEN-1:0]  a_ext_s, b_ext_s, prod_s, mul_tail_s;

   // Operation decode; codes outside the M extension decode to neither unit.
   always_comb begin
      is_mul_s     = 1'b0;
      is_div_s     = 1'b0;
      a_signed_s   = 1'b0;
      b_signed_s   = 1'b0;
      mul_hi_s     = 1'b0;
      div_signed_s = 1'b0;
      rem_sel_s    = 1'b0;
      case (mdu_control)
         ALU_MUL:    is_mul_s = 1'b1;
         ALU_MULH:   begin is_mul_s = 1'b1; mul_hi_s = 1'b1; a_signed_s = 1'b1; b_signed_s = 1'b1; end
         ALU_MULHSU: begin is_mul_s = 1'b1; mul_hi_s = 1'b1; a_signed_s = 1'b1; end
         ALU_MULHU:  begin is_mul_s = 1'b1; mul_hi_s = 1'b1; end
         ALU_DIV:    begin is_div_s = 1'b1; div_signed_s = 1'b1; end
         ALU_DIVU:   is_div_s = 1'b1;
         ALU_REM:    begin is_div_s = 1'b1; div_signed_s = 1'b1; rem_sel_s = 1'b1; end
         ALU_REMU:   begin is_div_s = 1'b1; rem_sel_s = 1'b1; end
         default:    is_mul_s = 1'b0;
      endcase
   end

   assign req_ready_s = !kill && ((state_r == IDLE) ||
                                  ((state_r == DONE) && res_valid_r && res_ack));
   assign accept_s    = req_valid && req_ready_s && (is_mul_s || is_div_s);
   assign target_s    = is_div_s ? DIV : ((MUL_STAGES == 0) ? DONE : MUL);

   // Restoring divider: DIV_BITS chained shift/trial-subtract steps per cycle.
   always_comb begin
      step_rem_s = rem_r;
      step_quo_s = quo_r;
      trial_s    = '0;
      for (int i = 0; i < DIV_BITS; i++) begin
         trial_s = {step_rem_s, step_quo_s[XLEN-1]} - {1'b0, dvs_r};
         if (!trial_s[XLEN]) begin
            step_rem_s = trial_s[XLEN-1:0];
            step_quo_s = {step_quo_s[XLEN-2:0], 1'b1};
         end else begin
            step_rem_s = {step_rem_s[XLEN-2:0], step_quo_s[XLEN-1]};
            step_quo_s = {step_quo_s[XLEN-2:0], 1'b0};
         end
      end
   end

`ifdef MDU_DIV_EARLY_OUT_EN
   // quo_r still holds |dividend| in the first busy cycle.
   assign early_s = (cnt_r == '0) && !dz_r && (quo_r < dvs_r);
`else
   assign early_s = 1'b0;
`endif

   assign div_fast_s = dz_r || ovf_r || early_s;

   // Final divide result including special cases and sign correction.
   always_comb begin
      div_res_s = '0;
      if (dz_r) begin
         div_res_s = rem_sel_r ? src1_r : '1;
      end else if (ovf_r) begin
         div_res_s = rem_sel_r ? '0 : MIN_VAL;
      end else if (early_s) begin
         div_res_s = rem_sel_r ? src1_r : '0;
      end else if (rem_sel_r) begin
         div_res_s = r_neg_r ? negate(step_rem_s) : step_rem_s;
      end else begin
         div_res_s = q_neg_r ? negate(step_quo_s) : step_quo_s;
      end
   end

   // Sign-extending both operands to 2*XLEN makes one unsigned multiply cover all variants.
   assign a_ext_s = {{XLEN{a_signed_r & src1_r[XLEN-1]}}, src1_r};
   assign b_ext_s = {{XLEN{b_signed_r & src2_r[XLEN-1]}}, src2_r};
   assign prod_s  = a_ext_s * b_ext_s;

   generate
      if (MUL_STAGES == 0) begin : g_no_pipe
         assign mul_tail_s = prod_s;
      end else begin : g_pipe
         logic [2*XLEN-1:0] pipe_r [MUL_STAGES];
         // Product retiming stages behind the multiplier.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < MUL_STAGES; i++) pipe_r[i] <= '0;
            end else begin
               pipe_r[0] <= prod_s;
               for (int i = 1; i < MUL_STAGES; i++) pipe_r[i] <= pipe_r[i-1];
            end
         end
         assign mul_tail_s = pipe_r[MUL_STAGES-1];
      end
   endgenerate

   assign mul_res_s = mul_hi_r ? mul_tail_s[2*XLEN-1:XLEN] : mul_tail_s[XLEN-1:0];

   // A multiply enters DONE with its result one cycle behind, so DONE without res_valid loads it.
   assign load_mul_s = (state_r == DONE) && !res_valid_r && !kill;
   assign load_div_s = (state_r == DIV) && !kill && (div_fast_s || (cnt_r == DIV_LAST));

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_n = target_s;
            else          state_n = IDLE;
         end
         MUL: begin
            if (kill)                    state_n = IDLE;
            else if (cnt_r == MUL_LAST)  state_n = DONE;
            else                         state_n = MUL;
         end
         DIV: begin
            if (kill)                                      state_n = IDLE;
            else if (div_fast_s || (cnt_r == DIV_LAST))    state_n = DONE;
            else                                           state_n = DIV;
         end
         DONE: begin
            if (kill) begin
               state_n = IDLE;
            end else if (res_valid_r && res_ack) begin
               if (accept_s) state_n = target_s;
               else          state_n = IDLE;
            end else begin
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Result register next values; the result is forced to zero whenever res_valid drops.
   always_comb begin
      valid_n  = load_div_s || load_mul_s ||
                 ((state_r == DONE) && res_valid_r && !res_ack && !kill);
      result_n = '0;
      if (load_div_s)      result_n = div_res_s;
      else if (load_mul_s) result_n = mul_res_s;
      else if (valid_n)    result_n = mdu_result_r;
      else                 result_n = '0;
   end

   // State, counter, operand latches and divider datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         res_valid_r  <= 1'b0;
         mdu_result_r <= '0;
         src1_r       <= '0;
         src2_r       <= '0;
         a_signed_r   <= 1'b0;
         b_signed_r   <= 1'b0;
         mul_hi_r     <= 1'b0;
         rem_sel_r    <= 1'b0;
         dz_r         <= 1'b0;
         ovf_r        <= 1'b0;
         q_neg_r      <= 1'b0;
         r_neg_r      <= 1'b0;
         quo_r        <= '0;
         rem_r        <= '0;
         dvs_r        <= '0;
      end else begin
         state_r      <= state_n;
         res_valid_r  <= valid_n;
         mdu_result_r <= result_n;
         if (accept_s) begin
            cnt_r      <= '0;
            src1_r     <= src1;
            src2_r     <= src2;
            a_signed_r <= a_signed_s;
            b_signed_r <= b_signed_s;
            mul_hi_r   <= mul_hi_s;
            rem_sel_r  <= rem_sel_s;
            dz_r       <= (src2 == '0);
            ovf_r      <= div_signed_s && (src1 == MIN_VAL) && (src2 == '1);
            q_neg_r    <= div_signed_s && (src1[XLEN-1] ^ src2[XLEN-1]);
            r_neg_r    <= div_signed_s && src1[XLEN-1];
            quo_r      <= abs_val(src1, div_signed_s);
            rem_r      <= '0;
            dvs_r      <= abs_val(src2, div_signed_s);
         end else if (state_r == DIV) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
            quo_r <= step_quo_s;
            rem_r <= step_rem_s;
         end else if (state_r == MUL) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end else begin
            cnt_r <= '0;
         end
      end
   end

   assign req_ready  = req_ready_s;
   assign res_valid  = res_valid_r;
   assign mdu_result = mdu_result_r;

endmodule

// File: tb/tb_mdu_pipelined.sv
// Directed self-checking bench for mdu_pipelined (main instance MUL_STAGES=0/DIV_BITS=1,
// second instance MUL_STAGES=3/DIV_BITS=4 sharing the request inputs).
module tb_mdu_pipelined;
   import mdu_pkg::*;

`ifdef MDU_DIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 32;
`endif

   logic         clk, rst, req_valid, kill, res_ack;
   logic [31:0]  src1, src2;
   alu_control_t ctrl;
   logic         req_ready_a, res_valid_a, req_ready_b, res_valid_b;
   logic [31:0]  result_a, result_b;
   int           checks = 0;
   int           failures = 0;

   mdu_pipelined #(.XLEN(32), .DIV_BITS(1), .MUL_STAGES(0)) dut (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .mdu_control(ctrl),
      .req_valid(req_valid), .req_ready(req_ready_a), .kill(kill),
      .res_valid(res_valid_a), .res_ack(res_ack), .mdu_result(result_a));

   mdu_pipelined #(.XLEN(32), .DIV_BITS(4), .MUL_STAGES(3)) dut_b (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .mdu_control(ctrl),
      .req_valid(req_valid), .req_ready(req_ready_b), .kill(kill),
      .res_valid(res_valid_b), .res_ack(res_ack), .mdu_result(result_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic issue(input alu_control_t op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      ctrl = op; src1 = a; src2 = b; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; ctrl = ALU_ADD; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
   endtask

   task automatic wait_res(input bit use_b, input int max_cyc, output int cyc);
      cyc = 0;
      while (((use_b ? res_valid_b : res_valid_a) !== 1'b1) && (cyc <= max_cyc)) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic ack();
      res_ack = 1'b1;
      @(negedge clk);
      res_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (res_valid_a !== 1'b0 || result_a !== 32'h0) begin
         failures++;
         $display("FAIL reset_out valid=%b result=%h required valid=0 result=0", res_valid_a, result_a);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready got=%b required=1", req_ready_a);
      end
   endtask

   task automatic test_mul();
      alu_control_t ops [5] = '{ALU_MULHU, ALU_MULH, ALU_MUL, ALU_MULHSU, ALU_MULH};
      logic [31:0]  av  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0]  bv  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0]  ev  [5] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h4000_0000};
      int lat;
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], av[i], bv[i]);
         wait_res(1'b0, 40, lat);
         checks++;
         if (lat !== 1) begin
            failures++;
            $display("FAIL mul_latency[%0d] got=%0d required=1", i, lat);
         end
         checks++;
         if (result_a !== ev[i]) begin
            failures++;
            $display("FAIL mul_result[%0d] got=%h required=%h", i, result_a, ev[i]);
         end
         if (i == 0) begin
            repeat (3) @(negedge clk);
            checks++;
            if (res_valid_a !== 1'b1 || result_a !== ev[i]) begin
               failures++;
               $display("FAIL mul_hold valid=%b result=%h required valid=1 result=%h", res_valid_a, result_a, ev[i]);
            end
         end
         ack();
      end
   endtask

   task automatic test_div();
      alu_control_t ops [6] = '{ALU_DIV, ALU_REM, ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM};
      logic [31:0]  av  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [31:0]  bv  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      logic [31:0]  ev  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001, 32'hFFFF_FFF2, 32'h0000_0002};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], av[i], bv[i]);
         wait_res(1'b0, 40, lat);
         checks++;
         if (lat !== 32) begin
            failures++;
            $display("FAIL div_latency[%0d] got=%0d required=32", i, lat);
         end
         checks++;
         if (result_a !== ev[i]) begin
            failures++;
            $display("FAIL div_result[%0d] got=%h required=%h", i, result_a, ev[i]);
         end
         ack();
      end
   endtask

   task automatic test_special();
      alu_control_t ops [7] = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM, ALU_DIV, ALU_REM, ALU_DIVU};
      logic [31:0]  av  [7] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000};
      logic [31:0]  bv  [7] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF};
      logic [31:0]  ev  [7] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000};
      int           el  [7] = '{1, 1, 1, 1, 1, 1, EARLY_LAT};
      int lat;
      for (int i = 0; i < 7; i++) begin
         issue(ops[i], av[i], bv[i]);
         wait_res(1'b0, 40, lat);
         checks++;
         if (lat !== el[i]) begin
            failures++;
            $display("FAIL special_latency[%0d] got=%0d required=%0d", i, lat, el[i]);
         end
         checks++;
         if (result_a !== ev[i]) begin
            failures++;
            $display("FAIL special_result[%0d] got=%h required=%h", i, result_a, ev[i]);
         end
         ack();
      end
   endtask

   task automatic test_kill();
      int lat;
      bit seen;
      issue(ALU_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      kill = 1'b1;
      #1;
      checks++;
      if (req_ready_a !== 1'b0) begin
         failures++;
         $display("FAIL kill_ready_low got=%b required=0", req_ready_a);
      end
      @(negedge clk);
      kill = 1'b0;
      #1;
      checks++;
      if (req_ready_a !== 1'b1 || res_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL kill_recover ready=%b valid=%b required ready=1 valid=0", req_ready_a, res_valid_a);
      end
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid_a) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL kill_no_result got valid seen=%b required=0", seen);
      end
      issue(ALU_DIVU, 32'd100, 32'd7);
      wait_res(1'b0, 40, lat);
      checks++;
      if (lat !== 32 || result_a !== 32'd14) begin
         failures++;
         $display("FAIL kill_reissue_divu lat=%0d result=%h required lat=32 result=0000000e", lat, result_a);
      end
      ack();
      issue(ALU_REMU, 32'd100, 32'd7);
      wait_res(1'b0, 40, lat);
      checks++;
      if (result_a !== 32'd2) begin
         failures++;
         $display("FAIL kill_reissue_remu got=%h required=00000002", result_a);
      end
      ack();
      // kill together with res_ack and a new request in DONE
      issue(ALU_MUL, 32'd5, 32'd6);
      wait_res(1'b0, 40, lat);
      ctrl = ALU_MUL; src1 = 32'd3; src2 = 32'd4; req_valid = 1'b1; res_ack = 1'b1; kill = 1'b1;
      #1;
      checks++;
      if (req_ready_a !== 1'b0) begin
         failures++;
         $display("FAIL kill_done_ready got=%b required=0", req_ready_a);
      end
      @(negedge clk);
      req_valid = 1'b0; res_ack = 1'b0; kill = 1'b0; ctrl = ALU_ADD;
      seen = 1'b0;
      repeat (5) begin
         if (res_valid_a || result_a !== 32'h0) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++;
         $display("FAIL kill_done_no_accept got valid/result seen=%b required=0", seen);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      issue(ALU_MUL, 32'd5, 32'd6);
      wait_res(1'b0, 40, lat);
      checks++;
      if (result_a !== 32'd30) begin
         failures++;
         $display("FAIL b2b_first got=%h required=0000001e", result_a);
      end
      ctrl = ALU_MUL; src1 = 32'd3; src2 = 32'd4; req_valid = 1'b1; res_ack = 1'b1;
      #1;
      checks++;
      if (req_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL b2b_ready got=%b required=1", req_ready_a);
      end
      @(negedge clk);
      req_valid = 1'b0; res_ack = 1'b0; ctrl = ALU_ADD; src1 = 32'hDEAD_BEEF; src2 = 32'h1234_5678;
      checks++;
      if (res_valid_a !== 1'b0) begin
         failures++;
         $display("FAIL b2b_gap got valid=%b required=0", res_valid_a);
      end
      wait_res(1'b0, 40, lat);
      checks++;
      if (lat !== 1 || result_a !== 32'd12) begin
         failures++;
         $display("FAIL b2b_second lat=%0d result=%h required lat=1 result=0000000c", lat, result_a);
      end
      ack();
   endtask

   task automatic test_invalid();
      @(negedge clk);
      ctrl = ALU_ADD; src1 = 32'd1; src2 = 32'd2; req_valid = 1'b1;
      #1;
      checks++;
      if (req_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL invalid_ready got=%b required=1", req_ready_a);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (res_valid_a !== 1'b0 || req_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL invalid_ignored valid=%b ready=%b required valid=0 ready=1", res_valid_a, req_ready_a);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit seen;
      issue(ALU_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (res_valid_a) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0 || req_ready_a !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_div valid seen=%b ready=%b required seen=0 ready=1", seen, req_ready_a);
      end
      issue(ALU_MUL, 32'd3, 32'd4);
      wait_res(1'b0, 40, lat);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (res_valid_a !== 1'b0 || result_a !== 32'h0) begin
         failures++;
         $display("FAIL reset_async valid=%b result=%h required valid=0 result=0", res_valid_a, result_a);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_early();
      alu_control_t ops [4] = '{ALU_DIVU, ALU_REMU, ALU_DIV, ALU_REM};
      logic [31:0]  av  [4] = '{32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
      logic [31:0]  ev  [4] = '{32'd0, 32'd3, 32'd0, 32'hFFFF_FFFD};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], av[i], 32'd10);
         wait_res(1'b0, 40, lat);
         checks++;
         if (lat !== EARLY_LAT || result_a !== ev[i]) begin
            failures++;
            $display("FAIL early[%0d] lat=%0d result=%h required lat=%0d result=%h", i, lat, result_a, EARLY_LAT, ev[i]);
         end
         ack();
      end
   endtask

   task automatic test_alt_config();
      alu_control_t ops [4] = '{ALU_MULHU, ALU_DIV, ALU_REM, ALU_DIVU};
      logic [31:0]  av  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
      logic [31:0]  bv  [4] = '{32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7};
      logic [31:0]  ev  [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14};
      int           el  [4] = '{4, 8, 8, 8};
      int lat;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], av[i], bv[i]);
         wait_res(1'b1, 40, lat);
         checks++;
         if (lat !== el[i] || result_b !== ev[i]) begin
            failures++;
            $display("FAIL alt[%0d] lat=%0d result=%h required lat=%0d result=%h", i, lat, result_b, el[i], ev[i]);
         end
         ack();
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; kill = 1'b0; res_ack = 1'b0;
      ctrl = ALU_ADD; src1 = 32'h0; src2 = 32'h0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_kill();
      test_back_to_back();
      test_invalid();
      test_reset_mid();
      test_early();
      test_alt_config();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
